// File: rtl/bank_pkg.sv
// Shared defaults and beat types for the bank xbar return path.
package bank_pkg;

    localparam int unsigned CH_NUM_DEF = 4;
    localparam int unsigned ROB_W_DEF  = 3;
    localparam int unsigned DATA_W_DEF = 128;
    localparam int unsigned CH_W_DEF   = (CH_NUM_DEF > 1) ? $clog2(CH_NUM_DEF) : 1;

    typedef logic [CH_W_DEF-1:0] ch_id_t;

    typedef struct packed {
        ch_id_t                 channel_id;
        logic [ROB_W_DEF-1:0]   rob_num;
        logic [DATA_W_DEF-1:0]  data;
    } rsp_beat_t;

endpackage

// File: rtl/bank_xbar_rtn_fifo.sv
// Single-channel synchronous FIFO with registered storage; head data reads as 0 while empty.
module bank_xbar_rtn_fifo
    import bank_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign cnt_o   = cnt_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: the empty gate masks stale contents.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/bank_xbar_rtn_queue.sv
// Return-path demux into per-channel FIFOs with ROB sequence checking.
// Optional input throttle enabled by defining BANK_XBAR_RTN_THROTTLE_EN.
module bank_xbar_rtn_queue
    import bank_pkg::*;
#(
    parameter int unsigned CH_NUM          = CH_NUM_DEF,
    parameter int unsigned CH_W            = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
    parameter int unsigned ROB_W           = ROB_W_DEF,
    parameter int unsigned DATA_W          = DATA_W_DEF,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned CNT_W           = $clog2(DEPTH) + 1,
    parameter int unsigned THROTTLE_PERIOD = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [CH_W-1:0]          in_channel_id_i,
    input  logic [ROB_W-1:0]         in_rob_num_i,
    input  logic [DATA_W-1:0]        in_data_i,
    output logic [CH_NUM-1:0]        out_valid_o,
    input  logic [CH_NUM-1:0]        out_ready_i,
    output logic [CH_NUM*ROB_W-1:0]  out_rob_num_o,
    output logic [CH_NUM*DATA_W-1:0] out_data_o,
    output logic [CH_NUM*CNT_W-1:0]  ch_cnt_o,
    output logic [CH_NUM-1:0]        rob_err_o,
    output logic                     illegal_ch_o
);

    localparam bit AllIdsLegal = (CH_NUM == (1 << CH_W));

    logic              ch_legal;
    logic [CH_NUM-1:0] ch_sel;
    logic [CH_NUM-1:0] ch_full;
    logic              thr_ok;
    logic              push_en;
    logic              illegal_q;

    if (AllIdsLegal) begin : g_all_legal
        assign ch_legal = 1'b1;
    end else begin : g_range_check
        assign ch_legal = (32'(in_channel_id_i) < CH_NUM);
    end

`ifdef BANK_XBAR_RTN_THROTTLE_EN
    localparam int unsigned ThrW = (THROTTLE_PERIOD > 1) ? $clog2(THROTTLE_PERIOD) : 1;

    logic [ThrW-1:0] thr_cnt_q, thr_cnt_d;

    assign thr_ok = (thr_cnt_q == ThrW'(THROTTLE_PERIOD - 1));

    always_comb begin
        thr_cnt_d = thr_cnt_q;
        if (in_valid_i || (thr_cnt_q != '0)) begin
            thr_cnt_d = thr_ok ? '0 : thr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) thr_cnt_q <= '0;
        else         thr_cnt_q <= thr_cnt_d;
    end
`else
    // Without the throttle every cycle is an acceptance slot.
    assign thr_ok = (THROTTLE_PERIOD > 0);
`endif

    // Illegal ids select no channel, so they are always ready and simply dropped.
    assign in_ready_o = !(|(ch_full & ch_sel)) && thr_ok;
    assign push_en    = in_valid_i && in_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                   illegal_q <= 1'b0;
        else if (push_en && !ch_legal) illegal_q <= 1'b1;
    end
    assign illegal_ch_o = illegal_q;

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        logic [ROB_W+DATA_W-1:0] rdata;
        logic [CNT_W-1:0]        cnt;
        logic                    empty;
        logic [ROB_W-1:0]        exp_rob_q;
        logic                    err_q;

        assign ch_sel[c] = ch_legal && (32'(in_channel_id_i) == c);

        bank_xbar_rtn_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (ROB_W + DATA_W),
            .CNT_W (CNT_W)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (push_en && ch_sel[c]),
            .wdata_i ({in_rob_num_i, in_data_i}),
            .pop_i   (out_ready_i[c]),
            .rdata_o (rdata),
            .cnt_o   (cnt),
            .empty_o (empty),
            .full_o  (ch_full[c])
        );

        // A mismatch resynchronises to the received rob so later beats check cleanly.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                exp_rob_q <= '0;
                err_q     <= 1'b0;
            end else if (push_en && ch_sel[c]) begin
                exp_rob_q <= in_rob_num_i + 1'b1;
                if (in_rob_num_i != exp_rob_q) err_q <= 1'b1;
            end
        end

        assign out_valid_o[c]                  = !empty;
        assign out_rob_num_o[c*ROB_W +: ROB_W] = rdata[DATA_W +: ROB_W];
        assign out_data_o[c*DATA_W +: DATA_W]  = rdata[DATA_W-1:0];
        assign ch_cnt_o[c*CNT_W +: CNT_W]      = cnt;
        assign rob_err_o[c]                    = err_q;
    end

endmodule

// File: tb/tb_bank_xbar_rtn_queue.sv
// Directed bench for bank_xbar_rtn_queue: vector table plus multi-cycle corner sequences.
module tb_bank_xbar_rtn_queue;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_ch;
    logic [2:0]   in_rob;
    logic [127:0] in_data;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [11:0]  out_rob;
    logic [511:0] out_data;
    logic [11:0]  ch_cnt;
    logic [3:0]   rob_err;
    logic         illegal_ch;

    // Second instance with a non-power-of-2 channel count for illegal ids.
    logic         in2_valid;
    logic         in2_ready;
    logic [1:0]   in2_ch;
    logic [2:0]   in2_rob;
    logic [7:0]   in2_data;
    logic [2:0]   out2_valid;
    logic [2:0]   out2_ready;
    logic [8:0]   out2_rob;
    logic [23:0]  out2_data;
    logic [5:0]   ch2_cnt;
    logic [2:0]   rob2_err;
    logic         illegal2_ch;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    bank_xbar_rtn_queue u_dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .in_channel_id_i (in_ch),
        .in_rob_num_i    (in_rob),
        .in_data_i       (in_data),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_rob_num_o   (out_rob),
        .out_data_o      (out_data),
        .ch_cnt_o        (ch_cnt),
        .rob_err_o       (rob_err),
        .illegal_ch_o    (illegal_ch)
    );

    bank_xbar_rtn_queue #(
        .CH_NUM (3),
        .DATA_W (8),
        .DEPTH  (2)
    ) u_dut3 (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .in_valid_i      (in2_valid),
        .in_ready_o      (in2_ready),
        .in_channel_id_i (in2_ch),
        .in_rob_num_i    (in2_rob),
        .in_data_i       (in2_data),
        .out_valid_o     (out2_valid),
        .out_ready_i     (out2_ready),
        .out_rob_num_o   (out2_rob),
        .out_data_o      (out2_data),
        .ch_cnt_o        (ch2_cnt),
        .rob_err_o       (rob2_err),
        .illegal_ch_o    (illegal2_ch)
    );

    typedef struct {
        logic       vld;
        logic [1:0] ch;
        logic [2:0] rob;
        logic [7:0] data;
        logic [3:0] rdy;
        logic       exp_rdy;
        logic [3:0] exp_ov;
        logic [11:0] exp_cnt;
        logic [7:0] exp_h1;
        logic [2:0] exp_r1;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_ch     = '0;
        in_rob    = '0;
        in_data   = '0;
        out_ready = '0;
        in2_valid = 1'b0;
        in2_ch    = '0;
        in2_rob   = '0;
        in2_data  = '0;
        out2_ready = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        #12;
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic beat(input logic [1:0] ch, input logic [2:0] rob, input logic [127:0] data,
                        input logic [3:0] rdy);
        in_valid  = 1'b1;
        in_ch     = ch;
        in_rob    = rob;
        in_data   = data;
        out_ready = rdy;
        tick();
        in_valid  = 1'b0;
    endtask

    initial begin
        idle_inputs();
        #12;
        rst_ni = 1'b1;
        tick();

        chk("rst_out_valid", 128'(out_valid), 128'h0);
        chk("rst_ch_cnt", 128'(ch_cnt), 128'h0);
        chk("rst_rob_err", 128'(rob_err), 128'h0);
        chk("rst_illegal", 128'(illegal_ch), 128'h0);
        chk("rst_out_data", 128'(out_data[127:0]), 128'h0);

`ifdef BANK_XBAR_RTN_THROTTLE_EN
        // Continuous valid to ch0: acceptance only when the period counter tops out.
        begin
            int accepted = 0;
            out_ready = 4'b0001;
            for (int i = 0; i < 9; i++) begin
                in_valid = 1'b1;
                in_ch    = 2'd0;
                in_rob   = 3'(accepted);
                in_data  = 128'(8'h50 + i);
                #1;
                chk($sformatf("thr_ready_c%0d", i), 128'(in_ready), 128'((i % 3) == 2));
                if (in_ready) accepted++;
                @(posedge clk_i);
                #1;
            end
            in_valid = 1'b0;
            chk("thr_accepted", 128'(accepted), 128'd3);
            chk("thr_rob_err", 128'(rob_err), 128'h0);
        end
`else
        vecs[0] = '{1'b1, 2'd1, 3'd0, 8'hA0, 4'b0000, 1'b1, 4'b0010, 12'o0010, 8'hA0, 3'd0};
        vecs[1] = '{1'b1, 2'd1, 3'd1, 8'hA1, 4'b0000, 1'b1, 4'b0010, 12'o0020, 8'hA0, 3'd0};
        vecs[2] = '{1'b1, 2'd1, 3'd2, 8'hA2, 4'b0000, 1'b1, 4'b0010, 12'o0030, 8'hA0, 3'd0};
        vecs[3] = '{1'b1, 2'd1, 3'd3, 8'hA3, 4'b0000, 1'b1, 4'b0010, 12'o0040, 8'hA0, 3'd0};
        vecs[4] = '{1'b1, 2'd1, 3'd4, 8'hFF, 4'b0000, 1'b0, 4'b0010, 12'o0040, 8'hA0, 3'd0};
        vecs[5] = '{1'b0, 2'd2, 3'd0, 8'h00, 4'b0000, 1'b1, 4'b0010, 12'o0040, 8'hA0, 3'd0};
        vecs[6] = '{1'b0, 2'd1, 3'd0, 8'h00, 4'b0010, 1'b0, 4'b0010, 12'o0030, 8'hA1, 3'd1};
        vecs[7] = '{1'b0, 2'd1, 3'd0, 8'h00, 4'b0010, 1'b1, 4'b0010, 12'o0020, 8'hA2, 3'd2};
        vecs[8] = '{1'b0, 2'd1, 3'd0, 8'h00, 4'b0010, 1'b1, 4'b0010, 12'o0010, 8'hA3, 3'd3};
        vecs[9] = '{1'b0, 2'd1, 3'd0, 8'h00, 4'b0010, 1'b1, 4'b0000, 12'o0000, 8'h00, 3'd0};

        for (int i = 0; i < 10; i++) begin
            in_valid  = vecs[i].vld;
            in_ch     = vecs[i].ch;
            in_rob    = vecs[i].rob;
            in_data   = 128'(vecs[i].data);
            out_ready = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d_in_ready", i), 128'(in_ready), 128'(vecs[i].exp_rdy));
            @(posedge clk_i);
            #1;
            chk($sformatf("v%0d_out_valid", i), 128'(out_valid), 128'(vecs[i].exp_ov));
            chk($sformatf("v%0d_ch_cnt", i), 128'(ch_cnt), 128'(vecs[i].exp_cnt));
            chk($sformatf("v%0d_head1_data", i), out_data[255:128], 128'(vecs[i].exp_h1));
            chk($sformatf("v%0d_head1_rob", i), 128'(out_rob[5:3]), 128'(vecs[i].exp_r1));
        end
        idle_inputs();
        chk("seq1_rob_err", 128'(rob_err), 128'h0);

        // Full ch0 with simultaneous push and pop: push refused, count drops.
        do_reset();
        for (int i = 0; i < 4; i++) beat(2'd0, 3'(i), 128'(8'hD0 + i), 4'b0000);
        in_valid  = 1'b1;
        in_ch     = 2'd0;
        in_rob    = 3'd4;
        in_data   = 128'hEE;
        out_ready = 4'b0001;
        #1;
        chk("full_pushpop_ready", 128'(in_ready), 128'h0);
        tick();
        idle_inputs();
        chk("full_pushpop_cnt", 128'(ch_cnt), 128'(12'o0003));
        chk("full_pushpop_head", out_data[127:0], 128'hD1);

        // ch2 rob wrap then a skip.
        do_reset();
        for (int i = 0; i < 9; i++) beat(2'd2, 3'(i % 8), 128'(i), 4'b0100);
        chk("rob_wrap_no_err", 128'(rob_err), 128'h0);
        beat(2'd2, 3'd5, 128'h55, 4'b0100);
        chk("rob_skip_err", 128'(rob_err), 128'(4'b0100));
        beat(2'd2, 3'd6, 128'h66, 4'b0100);
        beat(2'd2, 3'd7, 128'h77, 4'b0100);
        chk("rob_err_sticky", 128'(rob_err), 128'(4'b0100));

        // Interleaved beats with every consumer ready.
        do_reset();
        out_ready = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            int c;
            c = k % 4;
            in_valid = 1'b1;
            in_ch    = 2'(c);
            in_rob   = 3'(k / 4);
            in_data  = 128'(8'hC0 + k);
            #1;
            chk($sformatf("il%0d_ready", k), 128'(in_ready), 128'h1);
            @(posedge clk_i);
            #1;
            chk($sformatf("il%0d_out_valid", k), 128'(out_valid), 128'(4'b0001 << c));
            chk($sformatf("il%0d_data", k), out_data[c*128 +: 128], 128'(8'hC0 + k));
            chk($sformatf("il%0d_rob", k), 128'(out_rob[c*3 +: 3]), 128'(k / 4));
        end
        in_valid = 1'b0;
        tick();
        chk("il_drained_valid", 128'(out_valid), 128'h0);
        chk("il_drained_cnt", 128'(ch_cnt), 128'h0);
        chk("il_rob_err", 128'(rob_err), 128'h0);

        // Illegal channel id on the 3-channel instance.
        do_reset();
        chk("ill_pre", 128'(illegal2_ch), 128'h0);
        in2_valid = 1'b1;
        in2_ch    = 2'd3;
        in2_rob   = 3'd0;
        in2_data  = 8'h99;
        #1;
        chk("ill_ready", 128'(in2_ready), 128'h1);
        tick();
        in2_valid = 1'b0;
        chk("ill_flag", 128'(illegal2_ch), 128'h1);
        chk("ill_cnt", 128'(ch2_cnt), 128'h0);
        chk("ill_out_valid", 128'(out2_valid), 128'h0);
        chk("ill_rob_err", 128'(rob2_err), 128'h0);

        // Asynchronous reset with beats queued.
        do_reset();
        beat(2'd3, 3'd0, 128'h31, 4'b0000);
        beat(2'd3, 3'd1, 128'h32, 4'b0000);
        chk("arst_pre_valid", 128'(out_valid), 128'(4'b1000));
        chk("arst_pre_cnt", 128'(ch_cnt), 128'(12'o2000));
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid_now", 128'(out_valid), 128'h0);
        chk("arst_cnt_now", 128'(ch_cnt), 128'h0);
        #10;
        rst_ni = 1'b1;
        tick();
        chk("arst_post_cnt", 128'(ch_cnt), 128'h0);
        chk("arst_post_valid", 128'(out_valid), 128'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bank_xbar_rtn_queue.md
Name: bank_xbar_rtn_queue

Overview:
- Parametrised return-path buffer between the bank SRAM controller's xbar response port and CH_NUM xbar channel ports.
- Demultiplexes each response beat (channel id, rob number, data) into a per-channel FIFO.
- Drains each FIFO independently under per-channel valid/ready.
- Checks per-channel ROB sequencing and raises sticky error flags.

Parameters:
- CH_NUM, 4: number of xbar channels (2..8).
- CH_W, $clog2(CH_NUM) (min 1): channel id width.
- ROB_W, 3: rob number width.
- DATA_W, 128: response data width.
- DEPTH, 4: entries per channel FIFO (power of 2, ≥2).
- CNT_W, $clog2(DEPTH)+1: occupancy counter width.
- THROTTLE_PERIOD, 3: input acceptance period; used only with the optional feature.

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: reset, asynchronous assert, active-low.
- in_valid_i, in, 1: response beat valid.
- in_ready_o, out, 1: response beat accepted.
- in_channel_id_i, in, CH_W: destination channel.
- in_rob_num_i, in, ROB_W: rob number of the beat.
- in_data_i, in, DATA_W: beat data.
- out_valid_o, out, CH_NUM: per-channel head valid.
- out_ready_i, in, CH_NUM: per-channel consumer ready.
- out_rob_num_o, out, CH_NUM*ROB_W: per-channel head rob number; channel c occupies bits [c*ROB_W +: ROB_W].
- out_data_o, out, CH_NUM*DATA_W: per-channel head data; same packing.
- ch_cnt_o, out, CH_NUM*CNT_W: per-channel occupancy.
- rob_err_o, out, CH_NUM: sticky ROB-sequence error per channel.
- illegal_ch_o, out, 1: sticky flag for a beat with channel id ≥ CH_NUM.

Behaviour:
- Reset: one clock clk_i; rst_ni asynchronous, active-low. Reset clears all FIFO pointers and counts.
  - out_valid_o, ch_cnt_o, rob_err_o, illegal_ch_o = 0.
  - Expected-rob counters = 0.
  - out_data_o / out_rob_num_o are don't-care while out_valid is 0; they are driven 0 after reset.
- Accept: push occurs when in_valid_i && in_ready_o.
  - in_ready_o = (cnt[in_channel_id_i] != DEPTH), combinational from count only.
  - A pop in the same cycle does not free space for the push: no full-bypass.
  - Legal beats push into FIFO[in_channel_id_i].
- Illegal channel (id ≥ CH_NUM, non-power-of-2 CH_NUM only): in_ready_o=1, beat dropped, illegal_ch_o set next cycle.
- Latency: beat pushed at edge N is visible on out_valid_o/out_data_o from cycle N+1 (registered storage, no flow-through).
- Drain: pop channel c when out_valid_o[c] && out_ready_i[c]; the next entry is visible the following cycle.
  - Channels pop independently; all CH_NUM channels may pop in one cycle.
- Simultaneous push+pop on one channel: count unchanged; head advances; tail advances.
- Empty: out_valid_o[c]=0; out_ready_i[c] ignored.
- Full: in_ready_o deasserts only for beats targeting that channel; other channels are unaffected.
- Pointers: wrap modulo DEPTH; count range 0..DEPTH.
- ROB check on each accepted legal beat:
  - If in_rob_num_i != exp_rob[ch], set rob_err_o[ch]; it stays set until reset.
  - exp_rob[ch] then becomes in_rob_num_i+1, modulo 2^ROB_W, so the check resynchronises.
  - A matching beat increments exp_rob[ch], wrapping 2^ROB_W-1 -> 0.
- Reset mid-operation: all queued beats are discarded; outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro BANK_XBAR_RTN_THROTTLE_EN.
- Defined: a free-running counter thr_cnt (0..THROTTLE_PERIOD-1, reset 0) models a slow upstream xbar.
  - in_ready_o additionally requires thr_cnt == THROTTLE_PERIOD-1.
  - thr_cnt increments while in_valid_i is high or thr_cnt != 0, and wraps to 0 after THROTTLE_PERIOD-1.
  - With the default of 3, at most one beat is accepted per 3 cycles of continuous valid.
- Undefined: no counter; in_ready_o depends only on occupancy and channel legality.

Decomposition:
- Shared package bank_pkg:
  - channel count default.
  - ROB_W and DATA_W defaults.
  - a channel-id typedef.
  - a response-beat struct (channel_id, rob_num, data).
- Sub-module bank_xbar_rtn_fifo: single-channel synchronous FIFO (DEPTH, DATA_W+ROB_W) with push/pop/cnt/empty/full.
  - Instantiated CH_NUM times via generate.
  - The top holds demux, ROB checkers, throttle and flags.

Test Plan:
- Reset, then 4 beats to ch1 with rob 0,1,2,3, data 0xA0..0xA3; out_ready_i=0 -> ch_cnt[1]=4, in_ready_o=0 for ch1 and 1 for ch2. Then raise out_ready_i[1] -> data 0xA0..0xA3 emerge in order, one per cycle; rob_err_o=0.
- ch0 full with push to ch0 and pop of ch0 in the same cycle -> push refused (in_ready_o=0); count goes 4->3.
- ch2 receives rob 0..7 then 0 -> no error across the wrap. A following beat with rob 5 instead of 1 -> rob_err_o[2]=1; it stays set after later correct beats 6,7.
- Interleaved beats to ch0..ch3 with all out_ready_i=1 -> each beat appears on its channel exactly 1 cycle after acceptance; all counts return to 0.
- CH_NUM=3 build, beat with id 3 -> in_ready_o=1, no FIFO change, illegal_ch_o=1.
- THROTTLE_EN build with continuous in_valid_i to ch0 for 9 cycles -> exactly 3 beats accepted, at cycles 2, 5, 8.
- Assert rst_ni low with 2 beats queued -> out_valid_o clears immediately; counts are 0 after release.
